// File: rtl/l2_writeback_buffer.sv
// l2_writeback_buffer: FIFO of dirty L2 victim lines drained to pmem, with combinational probe and in-place coalescing.
module l2_writeback_buffer #(
  parameter int WIDTH = 256,
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_req,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] lookup_addr,
  output logic              lookup_hit,
  output logic [WIDTH-1:0]  lookup_data,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [WIDTH-1:0]  pmem_wdata,
  input  logic              pmem_resp,
  output logic [CW-1:0]     count,
  output logic              empty
);
  typedef enum logic {IDLE, WRITE} state_t;
  state_t state_q, state_n;
  logic [ADDR_W-6:0] tag_q [DEPTH];
  logic [WIDTH-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, tail_q, co_idx, widx;
  logic [CW-1:0] count_q;
  logic co_hit, push, app, pop, unused_ok;

  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + PW'(1);
  endfunction

  assign wb_ready = count_q != CW'(DEPTH);
  assign push = wb_req && wb_ready;
  assign app = push && !co_hit;
  assign pop = state_q == WRITE && pmem_resp;
  assign widx = co_hit ? co_idx : tail_q;
  assign count = count_q;
  assign empty = count_q == '0;
  assign pmem_write = state_q == WRITE;
  assign pmem_address = pmem_write ? {tag_q[head_q], 5'b0} : '0;
  assign pmem_wdata = pmem_write ? data_q[head_q] : '0;
  assign unused_ok = ^{wb_addr[4:0], lookup_addr[4:0]};

  always_comb begin
    state_n = state_q == IDLE ? (empty ? IDLE : WRITE) : (pmem_resp ? IDLE : WRITE);
  end

  // Walk oldest to youngest so a later match (append behind head-in-WRITE) wins.
  always_comb begin
    logic [PW-1:0] idx;
    idx = '0;
    lookup_hit = 1'b0;
    lookup_data = '0;
    co_hit = 1'b0;
    co_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = PW'((int'(head_q) + k) % DEPTH);
      if (k < int'(count_q) && tag_q[idx] == lookup_addr[ADDR_W-1:5]) begin
        lookup_hit = 1'b1;
        lookup_data = data_q[idx];
      end
      if (k < int'(count_q) && !(k == 0 && state_q == WRITE) && tag_q[idx] == wb_addr[ADDR_W-1:5]) begin
        co_hit = 1'b1;
        co_idx = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_n;
      if (app) tail_q <= inc(tail_q);
      if (pop) head_q <= inc(head_q);
      count_q <= count_q + CW'(app) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      tag_q[widx] <= wb_addr[ADDR_W-1:5];
      data_q[widx] <= wb_data;
    end
  end
endmodule

// File: tb/tb_l2_writeback_buffer.sv
// tb_l2_writeback_buffer: table-driven vectors plus an async-reset-mid-write sequence for l2_writeback_buffer.
module tb_l2_writeback_buffer;
  logic clk = 1'b0, rst_n = 1'b0;
  logic wb_req, wb_ready, lookup_hit, pmem_write, pmem_resp, empty;
  logic [31:0] wb_addr, lookup_addr, pmem_address;
  logic [255:0] wb_data, lookup_data, pmem_wdata;
  logic [2:0] count;
  int errors = 0, checks = 0;

  typedef struct {
    logic req; logic [31:0] addr; logic [7:0] db; logic [31:0] laddr; logic resp;
    logic hit; logic [7:0] lb; logic pw; logic [31:0] pa; logic [7:0] pb; int cnt;
  } vec_t;
  vec_t v [$];

  l2_writeback_buffer dut (
    .clk(clk), .rst_n(rst_n), .wb_req(wb_req), .wb_addr(wb_addr), .wb_data(wb_data),
    .wb_ready(wb_ready), .lookup_addr(lookup_addr), .lookup_hit(lookup_hit),
    .lookup_data(lookup_data), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .count(count), .empty(empty)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] d(input logic [7:0] b);
    return {32{b}};
  endfunction

  task automatic add(input logic req, input logic [31:0] addr, input logic [7:0] db, input logic [31:0] laddr,
                     input logic resp, input logic hit, input logic [7:0] lb, input logic pw,
                     input logic [31:0] pa, input logic [7:0] pb, input int cnt);
    vec_t r;
    r.req = req; r.addr = addr; r.db = db; r.laddr = laddr; r.resp = resp;
    r.hit = hit; r.lb = lb; r.pw = pw; r.pa = pa; r.pb = pb; r.cnt = cnt;
    v.push_back(r);
  endtask

  task automatic chk(input string name, input int row, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic [31:0] addr, input logic [255:0] data,
                       input logic [31:0] laddr, input logic resp);
    wb_req = req; wb_addr = addr; wb_data = data; lookup_addr = laddr; pmem_resp = resp;
  endtask

  initial begin
    // req addr db laddr resp | hit lb pw pa pb cnt
    add(0, 0, 0, 'h1040, 0, 0, 0, 0, 0, 0, 0);
    add(1, 'h1040, 'hAA, 'h1040, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 'h1040, 0, 1, 'hAA, 0, 0, 0, 1);
    add(0, 0, 0, 'h1040, 0, 1, 'hAA, 1, 'h1040, 'hAA, 1);
    add(0, 0, 0, 'h1040, 0, 1, 'hAA, 1, 'h1040, 'hAA, 1);
    add(0, 0, 0, 'h1040, 1, 1, 'hAA, 1, 'h1040, 'hAA, 1);
    add(0, 0, 0, 'h1040, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 'h1040, 1, 0, 0, 0, 0, 0, 0);
    add(1, 'h1100, 'h11, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 'h1200, 'h22, 'h1100, 0, 1, 'h11, 0, 0, 0, 1);
    add(1, 'h1300, 'h33, 0, 0, 0, 0, 1, 'h1100, 'h11, 2);
    add(1, 'h1400, 'h44, 0, 0, 0, 0, 1, 'h1100, 'h11, 3);
    add(1, 'h1500, 'h55, 'h1400, 0, 1, 'h44, 1, 'h1100, 'h11, 4);
    add(0, 0, 0, 'h1500, 0, 0, 0, 1, 'h1100, 'h11, 4);
    add(0, 0, 0, 0, 1, 0, 0, 1, 'h1100, 'h11, 4);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 1, 0, 0, 1, 'h1200, 'h22, 3);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2);
    add(0, 0, 0, 0, 1, 0, 0, 1, 'h1300, 'h33, 2);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 1, 0, 0, 1, 'h1400, 'h44, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 'h2000, 'hD1, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 'h201F, 'hD2, 'h2000, 0, 1, 'hD1, 0, 0, 0, 1);
    add(0, 0, 0, 'h2000, 1, 1, 'hD2, 1, 'h2000, 'hD2, 1);
    add(1, 'h3000, 'h30, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 'h3000, 0, 1, 'h30, 0, 0, 0, 1);
    add(1, 'h3000, 'hD3, 'h3000, 0, 1, 'h30, 1, 'h3000, 'h30, 1);
    add(0, 0, 0, 'h3000, 0, 1, 'hD3, 1, 'h3000, 'h30, 2);
    add(0, 0, 0, 'h4000, 1, 0, 0, 1, 'h3000, 'h30, 2);
    add(0, 0, 0, 'h3000, 0, 1, 'hD3, 0, 0, 0, 1);
    add(0, 0, 0, 'h3000, 1, 1, 'hD3, 1, 'h3000, 'hD3, 1);
    add(1, 'h5000, 'h50, 0, 0, 0, 0, 0, 0, 0, 0);
    add(1, 'h5100, 'h51, 0, 0, 0, 0, 0, 0, 0, 1);
    add(1, 'h5200, 'h52, 0, 0, 0, 0, 1, 'h5000, 'h50, 2);
    add(1, 'h5300, 'h53, 0, 0, 0, 0, 1, 'h5000, 'h50, 3);
    add(1, 'h5400, 'h54, 0, 1, 0, 0, 1, 'h5000, 'h50, 4);
    add(1, 'h5400, 'h54, 'h5400, 0, 0, 0, 0, 0, 0, 3);
    add(0, 0, 0, 0, 1, 0, 0, 1, 'h5100, 'h51, 4);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3);
    add(1, 'h5500, 'h55, 0, 1, 0, 0, 1, 'h5200, 'h52, 3);
    add(0, 0, 0, 'h5500, 0, 1, 'h55, 0, 0, 0, 3);

    drive(0, 0, '0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < v.size(); i++) begin
      if (i > 0) @(negedge clk);
      drive(v[i].req, v[i].addr, d(v[i].db), v[i].laddr, v[i].resp);
      #1;
      chk("count", i, count, v[i].cnt);
      chk("empty", i, empty, v[i].cnt == 0);
      chk("wb_ready", i, wb_ready, v[i].cnt != 4);
      chk("lookup_hit", i, lookup_hit, v[i].hit);
      chk("lookup_data", i, lookup_data, d(v[i].lb));
      chk("pmem_write", i, pmem_write, v[i].pw);
      chk("pmem_address", i, pmem_address, v[i].pa);
      chk("pmem_wdata", i, pmem_wdata, d(v[i].pb));
    end

    // Three entries queued, head 0x5300 enters WRITE, then reset drops everything without a clock edge.
    @(negedge clk);
    drive(0, 0, '0, 'h5300, 0);
    #1;
    chk("pre_rst_write", 100, pmem_write, 1'b1);
    chk("pre_rst_addr", 100, pmem_address, 32'h5300);
    chk("pre_rst_hit", 100, lookup_hit, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_write", 101, pmem_write, 1'b0);
    chk("rst_count", 101, count, 0);
    chk("rst_ready", 101, wb_ready, 1'b1);
    chk("rst_empty", 101, empty, 1'b1);
    chk("rst_addr", 101, pmem_address, 0);
    chk("rst_wdata", 101, pmem_wdata, 0);
    chk("rst_hit", 101, lookup_hit, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_write", 102, pmem_write, 1'b0);
    chk("post_rst_count", 102, count, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
